// File: rtl/exec_pkg.sv
// Shared constants for the EX stage: ALU opcodes and default datapath widths.
package exec_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int REG_AW_DEF = 3;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

endpackage

// File: rtl/exec_alu.sv
// Combinational ALU: ADD/SUB wrap modulo 2^DATA_W with no flags, AND/OR bitwise.
module exec_alu
    import exec_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] y
);

    always_comb begin
        y = '0;
        case (op)
            ALU_ADD: y = a + b;
            ALU_SUB: y = a - b;
            ALU_AND: y = a & b;
            ALU_OR:  y = a | b;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/execution_stage.sv
// EX stage: result select (branch/jump offset, LDI, LD/ST address, ALU),
// branch resolution, and the EX/MEM output register.
module execution_stage
    import exec_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pc_w,
    input  logic              mem_w,
    input  logic              is_eq,
    input  logic              is_ldi,
    input  logic              is_ld_st,
    input  logic              is_jump,
    input  logic [1:0]        alith,
    input  logic [REG_AW-1:0] rd_addr,
    input  logic [5:0]        disp6,
    input  logic [8:0]        imm9,
    input  logic [DATA_W-1:0] rd,
    input  logic [DATA_W-1:0] rs,
    input  logic [DATA_W-1:0] source1,
    input  logic [DATA_W-1:0] source2,
    output logic              pc_w_out,
    output logic              mem_w_out,
    output logic [REG_AW-1:0] rd_addr_out,
    output logic [DATA_W-1:0] result
);

    logic [DATA_W-1:0] w_alu_y;
    logic [DATA_W-1:0] w_result_nxt;
    logic              w_cmp_true;
    logic              w_pc_w_nxt;

    // Raw instruction fields ride along for debug visibility only.
    logic w_unused_fields;
    assign w_unused_fields = ^{disp6, imm9};

    exec_alu #(.DATA_W(DATA_W)) u_alu (
        .op (alith),
        .a  (source1),
        .b  (source2),
        .y  (w_alu_y)
    );

    // Priority: PC target, then LDI, then LD/ST address, then ALU.
    always_comb begin
        w_result_nxt = w_alu_y;
        if (pc_w)
            w_result_nxt = source2;
        else if (is_ldi)
            w_result_nxt = source2;
        else if (is_ld_st)
            w_result_nxt = rs + source2;
    end

    // BGT compares as signed two's complement; a jump ignores the compare.
    assign w_cmp_true = is_eq ? (rd == rs) : ($signed(rd) > $signed(rs));
    assign w_pc_w_nxt = pc_w & (is_jump | w_cmp_true);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_w_out    <= 1'b0;
            mem_w_out   <= 1'b0;
            rd_addr_out <= '0;
            result      <= '0;
        end else begin
            pc_w_out    <= w_pc_w_nxt;
            mem_w_out   <= mem_w;
            rd_addr_out <= rd_addr;
            result      <= w_result_nxt;
        end
    end

endmodule

// File: tb/tb_execution_stage.sv
// Bench for execution_stage: directed plan steps plus random stimulus against
// an arithmetic reference model.
module tb_execution_stage;

    logic        clk;
    logic        rst_n;
    logic        pc_w, mem_w, is_eq, is_ldi, is_ld_st, is_jump;
    logic [1:0]  alith;
    logic [2:0]  rd_addr;
    logic [5:0]  disp6;
    logic [8:0]  imm9;
    logic [15:0] rd, rs, source1, source2;
    logic        pc_w_out, mem_w_out;
    logic [2:0]  rd_addr_out;
    logic [15:0] result;

    int errors = 0;
    int checks = 0;

    execution_stage dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pc_w        (pc_w),
        .mem_w       (mem_w),
        .is_eq       (is_eq),
        .is_ldi      (is_ldi),
        .is_ld_st    (is_ld_st),
        .is_jump     (is_jump),
        .alith       (alith),
        .rd_addr     (rd_addr),
        .disp6       (disp6),
        .imm9        (imm9),
        .rd          (rd),
        .rs          (rs),
        .source1     (source1),
        .source2     (source2),
        .pc_w_out    (pc_w_out),
        .mem_w_out   (mem_w_out),
        .rd_addr_out (rd_addr_out),
        .result      (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int to_signed16(input logic [15:0] v);
        int u;
        u = int'(v);
        return (u >= 32768) ? u - 65536 : u;
    endfunction

    function automatic logic [15:0] model_result();
        int a, b, r;
        a = int'(source1);
        b = int'(source2);
        if (pc_w || is_ldi) return source2;
        if (is_ld_st) begin
            r = (int'(rs) + b) % 65536;
            return r[15:0];
        end
        case (int'(alith))
            0:       r = (a + b) % 65536;
            1:       r = (a - b + 65536) % 65536;
            2:       r = a & b;
            default: r = a | b;
        endcase
        return r[15:0];
    endfunction

    function automatic logic model_pcw();
        logic taken;
        if (is_eq) taken = (int'(rd) == int'(rs));
        else       taken = (to_signed16(rd) > to_signed16(rs));
        return pc_w && (is_jump || taken);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_in();
        pc_w = 0; mem_w = 0; is_eq = 0; is_ldi = 0; is_ld_st = 0; is_jump = 0;
        alith = 2'b00; rd_addr = 3'd0; disp6 = '0; imm9 = '0;
        rd = '0; rs = '0; source1 = '0; source2 = '0;
    endtask

    // Capture the model's view of the current inputs, clock once, compare.
    task automatic step(input string tag);
        logic [15:0] e_res;
        logic        e_pcw, e_memw;
        logic [2:0]  e_rda;
        e_res  = model_result();
        e_pcw  = model_pcw();
        e_memw = mem_w;
        e_rda  = rd_addr;
        @(posedge clk);
        #1;
        chk({tag, ".result"},  32'(result),      32'(e_res));
        chk({tag, ".pcw"},     32'(pc_w_out),    32'(e_pcw));
        chk({tag, ".memw"},    32'(mem_w_out),   32'(e_memw));
        chk({tag, ".rdaddr"},  32'(rd_addr_out), 32'(e_rda));
    endtask

    initial begin
        clear_in();
        rst_n = 1'b0;
        source1 = 16'd10; source2 = 16'd20; rd_addr = 3'd5;
        @(posedge clk);
        #1;
        chk("rst.result", 32'(result), 32'd0);
        chk("rst.pcw",    32'(pc_w_out), 32'd0);
        chk("rst.memw",   32'(mem_w_out), 32'd0);
        chk("rst.rdaddr", 32'(rd_addr_out), 32'd0);
        rst_n = 1'b1;

        clear_in(); rd_addr = 3'd1; alith = 2'b00; source1 = 16'd10; source2 = 16'd20;
        step("add"); chk("add.const", 32'(result), 32'd30); chk("add.rda", 32'(rd_addr_out), 32'd1);
        alith = 2'b01; source1 = 16'd20; source2 = 16'd10;
        step("sub"); chk("sub.const", 32'(result), 32'd10);
        alith = 2'b10; source1 = 16'd12; source2 = 16'd8;
        step("and"); chk("and.const", 32'(result), 32'd8);
        alith = 2'b11; source1 = 16'd8; source2 = 16'd1;
        step("or"); chk("or.const", 32'(result), 32'd9);
        alith = 2'b01; source1 = 16'd0; source2 = 16'd1;
        step("subwrap"); chk("subwrap.const", 32'(result), 32'hFFFF);

        clear_in(); alith = 2'b00; source1 = 16'd10; source2 = 16'd3;
        step("addi"); chk("addi.const", 32'(result), 32'd13);
        alith = 2'b01;
        step("subi"); chk("subi.const", 32'(result), 32'd7);
        alith = 2'b00; is_ldi = 1;
        step("ldi"); chk("ldi.const", 32'(result), 32'd3);
        is_ld_st = 1; rs = 16'd20;
        step("ldi_over_ldst"); chk("ldi_over_ldst.const", 32'(result), 32'd3);

        clear_in(); is_ld_st = 1; rs = 16'd20; source2 = 16'd3; mem_w = 1; rd_addr = 3'd0;
        step("st"); chk("st.const", 32'(result), 32'd23); chk("st.memw", 32'(mem_w_out), 32'd1);

        clear_in(); pc_w = 1; is_eq = 1; rd = 16'd10; rs = 16'd10; source2 = 16'd3;
        step("beq_t"); chk("beq_t.pcw", 32'(pc_w_out), 32'd1); chk("beq_t.res", 32'(result), 32'd3);
        rs = 16'd11;
        step("beq_n"); chk("beq_n.pcw", 32'(pc_w_out), 32'd0);
        is_eq = 0; rd = 16'd20; rs = 16'd10;
        step("bgt_t"); chk("bgt_t.pcw", 32'(pc_w_out), 32'd1);
        rd = 16'hFFFF; rs = 16'd1;
        step("bgt_signed"); chk("bgt_signed.pcw", 32'(pc_w_out), 32'd0);
        rd = 16'd1; rs = 16'h8000;
        step("bgt_neg_rs"); chk("bgt_neg_rs.pcw", 32'(pc_w_out), 32'd1);
        is_jump = 1; is_eq = 1; rd = 16'd0; rs = 16'd5;
        step("jump"); chk("jump.pcw", 32'(pc_w_out), 32'd1); chk("jump.res", 32'(result), 32'd3);

        // Asynchronous reset between edges, then recovery.
        clear_in(); rd_addr = 3'd1; source1 = 16'd10; source2 = 16'd20; mem_w = 1;
        step("pre_rst");
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst.result", 32'(result), 32'd0);
        chk("async_rst.memw",   32'(mem_w_out), 32'd0);
        chk("async_rst.rdaddr", 32'(rd_addr_out), 32'd0);
        #3 rst_n = 1'b1;
        step("post_rst"); chk("post_rst.const", 32'(result), 32'd30);

        // Back-to-back ADD / BEQ with no bubbles.
        for (int i = 0; i < 8; i++) begin
            clear_in();
            if (i % 2 == 0) begin
                rd_addr = 3'(i); source1 = 16'(i * 100); source2 = 16'd7;
            end else begin
                pc_w = 1; is_eq = 1; rd = 16'(i); rs = (i % 4 == 1) ? 16'(i) : 16'(i + 1);
                source2 = 16'(i + 40);
            end
            step("b2b");
        end

        for (int i = 0; i < 400; i++) begin
            pc_w     = 1'($urandom_range(0, 3) == 0);
            mem_w    = 1'($urandom);
            is_eq    = 1'($urandom);
            is_ldi   = 1'($urandom_range(0, 4) == 0);
            is_ld_st = 1'($urandom_range(0, 3) == 0);
            is_jump  = 1'($urandom_range(0, 3) == 0);
            alith    = 2'($urandom);
            rd_addr  = 3'($urandom);
            disp6    = 6'($urandom);
            imm9     = 9'($urandom);
            rd       = 16'($urandom);
            rs       = ($urandom_range(0, 3) == 0) ? rd : 16'($urandom);
            source1  = 16'($urandom);
            source2  = 16'($urandom);
            step("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
